// File: rtl/ipv4_hdr_assembler.sv
// rtl/ipv4_hdr_assembler.sv - packs the first DATA_WIDTH bits of each sop/eop framed packet into one header vector
// Words fill a NUM_WORDS*IN_WIDTH buffer from the MSB down; the top DATA_WIDTH bits are presented with a valid pulse.

module ipv4_hdr_assembler #(
    parameter int DATA_WIDTH = 480,
    parameter int IN_WIDTH   = 64,
    parameter int NUM_WORDS  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_vld,
    input  logic                  in_sop,
    input  logic                  in_eop,
    input  logic [IN_WIDTH-1:0]   in_data,
    output logic                  pkt_data_vld_out,
    output logic [DATA_WIDTH-1:0] pkt_data_out,
    output logic                  hdr_short,
    output logic [31:0]           pkt_cnt,
    output logic [15:0]           short_cnt,
    output logic [15:0]           err_cnt
);

    localparam int BUF_W = NUM_WORDS * IN_WIDTH;
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [BUF_W-1:0]   hdr_buf;
    logic [BUF_W-1:0]   buf_nxt;
    logic [IDX_W-1:0]   wr_idx;

    // A sop word always restarts the buffer from a cleared state at slot 0,
    // so stale words from an abandoned packet can never leak into a header.
    always_comb begin
        wr_idx  = in_sop ? '0 : idx;
        buf_nxt = in_sop ? '0 : hdr_buf;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (wr_idx == IDX_W'(k)) begin
                buf_nxt[BUF_W-1-k*IN_WIDTH -: IN_WIDTH] = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            idx              <= '0;
            hdr_buf          <= '0;
            pkt_data_vld_out <= 1'b0;
            pkt_data_out     <= '0;
            hdr_short        <= 1'b0;
            pkt_cnt          <= '0;
            short_cnt        <= '0;
            err_cnt          <= '0;
        end else begin
            pkt_data_vld_out <= 1'b0;
            hdr_short        <= 1'b0;
            if (in_vld) begin
                if (in_sop) begin
                    if (state != IDLE) begin
                        err_cnt <= err_cnt + 16'd1;
                    end
                    hdr_buf <= buf_nxt;
                    idx     <= IDX_W'(1);
                    if (in_eop) begin
                        pkt_data_vld_out <= 1'b1;
                        hdr_short        <= 1'b1;
                        pkt_data_out     <= buf_nxt[BUF_W-1 -: DATA_WIDTH];
                        pkt_cnt          <= pkt_cnt + 32'd1;
                        short_cnt        <= short_cnt + 16'd1;
                        state            <= IDLE;
                    end else begin
                        state <= COLLECT;
                    end
                end else begin
                    case (state)
                        IDLE: begin
                            err_cnt <= err_cnt + 16'd1;
                        end
                        COLLECT: begin
                            hdr_buf <= buf_nxt;
                            if (idx == LAST_IDX) begin
                                pkt_data_vld_out <= 1'b1;
                                pkt_data_out     <= buf_nxt[BUF_W-1 -: DATA_WIDTH];
                                pkt_cnt          <= pkt_cnt + 32'd1;
                                idx              <= '0;
                                state            <= in_eop ? IDLE : DRAIN;
                            end else if (in_eop) begin
                                pkt_data_vld_out <= 1'b1;
                                hdr_short        <= 1'b1;
                                pkt_data_out     <= buf_nxt[BUF_W-1 -: DATA_WIDTH];
                                pkt_cnt          <= pkt_cnt + 32'd1;
                                short_cnt        <= short_cnt + 16'd1;
                                idx              <= '0;
                                state            <= IDLE;
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end
                        DRAIN: begin
                            if (in_eop) begin
                                state <= IDLE;
                            end
                        end
                        default: begin
                            state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule
